// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default sizes, the width helper
// and the op record passed from decode into stack_unit.
package stack_pkg;

    localparam int DEF_DEPTH   = 128;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_MAX_POP = 8;
    localparam int DEF_NPREV   = 2;

    // Bits needed to hold any value in 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DEF_CW = cnt_width(DEF_DEPTH);
    localparam int DEF_PW = cnt_width(DEF_MAX_POP);

    typedef struct packed {
        logic              push;
        logic [DEF_PW-1:0] pop_cnt;
    } stack_op_t;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH register array, one synchronous write port and
// NRD asynchronous read ports. Contents are never reset.
module stack_mem #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32,
    parameter int AW    = 7,
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [NRD*AW-1:0]    i_raddr,
    output logic [NRD*WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        assign o_rdata[gi*WIDTH +: WIDTH] = r_mem[i_raddr[gi*AW +: AW]];
    end

endmodule

// File: rtl/stack_unit.sv
// Operand stack with multi-pop, pop-then-push, preview taps, sticky error flags
// and a high-water mark. Optional random-access peek port under STACK_PEEK_EN.
module stack_unit
    import stack_pkg::*;
#(
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int MAX_POP = DEF_MAX_POP,
    parameter  int NPREV   = DEF_NPREV,
    localparam int CW      = cnt_width(DEPTH),
    localparam int PW      = cnt_width(MAX_POP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic [PW-1:0]          pop_cnt,
    input  logic                   err_clr,
`ifdef STACK_PEEK_EN
    input  logic [CW-1:0]          peek_idx,
    output logic [WIDTH-1:0]       peek_data,
`endif
    output logic [NPREV*WIDTH-1:0] preview,
    output logic [CW-1:0]          count,
    output logic                   empty,
    output logic                   full,
    output logic [CW-1:0]          hwm,
    output logic                   err_overflow,
    output logic                   err_underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW = CW + 1;
`ifdef STACK_PEEK_EN
    localparam int NRD = NPREV + 1;
`else
    localparam int NRD = NPREV;
`endif

    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_hwm;
    logic                 r_err_ovf;
    logic                 r_err_unf;

    logic [XW-1:0]        w_c_ext;
    logic [XW-1:0]        w_pop_ext;
    logic [XW-1:0]        w_m;
    logic [CW-1:0]        w_count_next;
    logic [CW-1:0]        w_hwm_base;
    logic [CW-1:0]        w_hwm_next;
    logic                 w_underflow;
    logic                 w_overflow;
    logic                 w_we;
    logic [NRD*AW-1:0]    w_raddr;
    logic [NRD*WIDTH-1:0] w_rdata;

    // Extra bit keeps c - pop_cnt from wrapping when the pop is rejected.
    assign w_c_ext   = XW'(r_count);
    assign w_pop_ext = XW'(pop_cnt);
    assign w_m       = w_c_ext - w_pop_ext;

    always_comb begin
        w_underflow  = (w_pop_ext > w_c_ext) || (pop_cnt > PW'(MAX_POP));
        w_overflow   = 1'b0;
        w_we         = 1'b0;
        w_count_next = r_count;
        if (!w_underflow) begin
            w_count_next = CW'(w_m);
            if (push) begin
                if (w_m < XW'(DEPTH)) begin
                    w_we         = 1'b1;
                    w_count_next = CW'(w_m + XW'(1));
                end else begin
                    w_overflow = 1'b1;
                end
            end
        end
    end

    assign w_hwm_base = err_clr ? r_count : r_hwm;
    assign w_hwm_next = (w_count_next > w_hwm_base) ? w_count_next : w_hwm_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_hwm     <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_hwm     <= w_hwm_next;
            r_err_ovf <= w_overflow  | (r_err_ovf & ~err_clr);
            r_err_unf <= w_underflow | (r_err_unf & ~err_clr);
        end
    end

    stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW),
        .NRD   (NRD)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we & rst_n),
        .i_waddr (AW'(w_m)),
        .i_wdata (push_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Tap i reads i entries below the top; out-of-range taps are forced to zero.
    for (genvar gi = 0; gi < NPREV; gi++) begin : g_tap
        assign w_raddr[gi*AW +: AW] = AW'(r_count - CW'(gi + 1));
        assign preview[gi*WIDTH +: WIDTH] =
            (w_c_ext > XW'(gi)) ? w_rdata[gi*WIDTH +: WIDTH] : '0;
    end

`ifdef STACK_PEEK_EN
    assign w_raddr[NPREV*AW +: AW] = AW'(r_count - peek_idx - CW'(1));
    assign peek_data = (peek_idx < r_count) ? w_rdata[NPREV*WIDTH +: WIDTH] : '0;
`endif

    assign count         = r_count;
    assign empty         = (r_count == '0);
    assign full          = (XW'(r_count) == XW'(DEPTH));
    assign hwm           = r_hwm;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed vector table, hand-written
// corner sequences and random ops checked against a queue-based stack model.
module tb_stack_unit;

    localparam int DEPTH   = 128;
    localparam int WIDTH   = 32;
    localparam int MAX_POP = 8;
    localparam int NPREV   = 2;
    localparam int CW      = 8;
    localparam int PW      = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   push;
    logic [WIDTH-1:0]       push_data;
    logic [PW-1:0]          pop_cnt;
    logic                   err_clr;
    logic [NPREV*WIDTH-1:0] preview;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic [CW-1:0]          hwm;
    logic                   err_overflow;
    logic                   err_underflow;
`ifdef STACK_PEEK_EN
    logic [CW-1:0]          peek_idx;
    logic [WIDTH-1:0]       peek_data;
`endif

    stack_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (push_data),
        .pop_cnt       (pop_cnt),
        .err_clr       (err_clr),
`ifdef STACK_PEEK_EN
        .peek_idx      (peek_idx),
        .peek_data     (peek_data),
`endif
        .preview       (preview),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .hwm           (hwm),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a plain queue whose back is the top of stack.
    logic [WIDTH-1:0] m_stk[$];
    int               m_hwm;
    bit               m_ovf;
    bit               m_unf;
    int               cur_pk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit p, input logic [WIDTH-1:0] d,
                              input int pop, input bit clr);
        int c;
        int base;
        bit un;
        bit ov;
        if (rst) begin
            m_stk.delete();
            m_hwm = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            c  = m_stk.size();
            un = (pop > c) || (pop > MAX_POP);
            ov = 0;
            if (!un) begin
                for (int k = 0; k < pop; k++) void'(m_stk.pop_back());
                if (p) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(d);
                    else ov = 1;
                end
            end
            m_unf = un || (m_unf && !clr);
            m_ovf = ov || (m_ovf && !clr);
            base  = clr ? c : m_hwm;
            m_hwm = (m_stk.size() > base) ? m_stk.size() : base;
        end
    endtask

    task automatic check_model();
        int sz;
        logic [WIDTH-1:0] e;
        sz = m_stk.size();
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("hwm", 32'(hwm), 32'(m_hwm));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_underflow", 32'(err_underflow), 32'(m_unf));
        for (int i = 0; i < NPREV; i++) begin
            e = (i < sz) ? m_stk[sz-1-i] : '0;
            chk($sformatf("preview%0d", i), preview[i*WIDTH +: WIDTH], e);
        end
`ifdef STACK_PEEK_EN
        e = (cur_pk < sz) ? m_stk[sz-1-cur_pk] : '0;
        chk("peek_data", peek_data, e);
`endif
    endtask

    task automatic do_op(input bit rst, input bit p, input logic [WIDTH-1:0] d,
                         input int pop, input bit clr, input int pk);
        @(negedge clk);
        rst_n     = !rst;
        push      = p;
        push_data = d;
        pop_cnt   = PW'(pop);
        err_clr   = clr;
        cur_pk    = pk;
`ifdef STACK_PEEK_EN
        peek_idx  = CW'(pk);
`endif
        @(posedge clk);
        #1;
        model_step(rst, p, d, pop, clr);
        check_model();
        $display("op rst=%0d push=%0d data=%0h pop=%0d clr=%0d -> count=%0d p0=%0h ovf=%0d unf=%0d",
                 rst, p, d, pop, clr, count, preview[WIDTH-1:0], err_overflow, err_underflow);
    endtask

    typedef struct {
        logic        push;
        logic [31:0] data;
        int          pop;
        logic        clr;
        logic [7:0]  e_count;
        logic [31:0] e_p0;
        logic [31:0] e_p1;
        logic [7:0]  e_hwm;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit p;
        int pop;
        rst_n = 1'b0; push = 1'b0; push_data = '0; pop_cnt = '0; err_clr = 1'b0; cur_pk = 0;
`ifdef STACK_PEEK_EN
        peek_idx = '0;
`endif
        vecs[0] = '{1'b1, 32'hA, 0, 1'b0, 8'd1, 32'hA, 32'h0, 8'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'hB, 0, 1'b0, 8'd2, 32'hB, 32'hA, 8'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'hC, 0, 1'b0, 8'd3, 32'hC, 32'hB, 8'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'hD, 2, 1'b0, 8'd2, 32'hD, 32'hA, 8'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0, 1, 1'b0, 8'd1, 32'hA, 32'h0, 8'd3, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 0, 1'b0, 8'd1, 32'hA, 32'h0, 8'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'hE, 3, 1'b0, 8'd1, 32'hA, 32'h0, 8'd3, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 32'hF, 1, 1'b1, 8'd1, 32'hF, 32'h0, 8'd1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h0, 3, 1'b1, 8'd1, 32'hF, 32'h0, 8'd1, 1'b0, 1'b1};

        // Reset with push asserted: reset must win.
        do_op(1, 1, 32'h55, 0, 0, 0);
        do_op(1, 1, 32'h66, 0, 1, 0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 9; i++) begin
            do_op(0, vecs[i].push, vecs[i].data, vecs[i].pop, vecs[i].clr, 0);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_p0", i), preview[31:0], vecs[i].e_p0);
            chk($sformatf("vec%0d_p1", i), preview[63:32], vecs[i].e_p1);
            chk($sformatf("vec%0d_hwm", i), 32'(hwm), 32'(vecs[i].e_hwm));
            chk($sformatf("vec%0d_ovf", i), 32'(err_overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_unf", i), 32'(err_underflow), 32'(vecs[i].e_unf));
        end

        // Fill to DEPTH, then overflow, then replace-at-full.
        for (int k = 0; k < DEPTH - 1; k++) do_op(0, 1, 32'h100 + k, 0, 0, 0);
        chk("fill_count", 32'(count), 32'd128);
        chk("fill_full", 32'(full), 32'd1);
        do_op(0, 1, 32'hE, 0, 0, 0);
        chk("ovf_count", 32'(count), 32'd128);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        chk("ovf_p0", preview[31:0], 32'h17E);
        do_op(0, 1, 32'hF, 1, 0, 0);
        chk("repl_count", 32'(count), 32'd128);
        chk("repl_p0", preview[31:0], 32'hF);
        chk("repl_p1", preview[63:32], 32'h17D);
        do_op(0, 0, 32'h0, 9, 0, 0);
        chk("pop9_count", 32'(count), 32'd128);
        chk("pop9_unf", 32'(err_underflow), 32'd1);
        do_op(0, 0, 32'h0, 8, 0, 0);
        chk("pop8_count", 32'(count), 32'd120);
        chk("pop8_hwm", 32'(hwm), 32'd128);
        do_op(0, 0, 32'h0, 0, 1, 0);
        chk("clr_hwm", 32'(hwm), 32'd120);
        chk("clr_ovf", 32'(err_overflow), 32'd0);
        chk("clr_unf", 32'(err_underflow), 32'd0);

        // Mid-sequence reset with a push.
        do_op(1, 1, 32'h77, 1, 0, 0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_hwm", 32'(hwm), 32'd0);
        chk("mrst_p0", preview[31:0], 32'h0);

`ifdef STACK_PEEK_EN
        for (int k = 1; k <= 5; k++) do_op(0, 1, 32'(k), 0, 0, 0);
        do_op(0, 0, 32'h0, 0, 0, 4);
        chk("peek4", peek_data, 32'd1);
        do_op(0, 0, 32'h0, 0, 0, 5);
        chk("peek5", peek_data, 32'd0);
`endif

        // Random traffic: push-heavy first half, pop-heavy second half.
        for (int i = 0; i < 1500; i++) begin
            p = (i < 750) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) < ((i < 750) ? 8 : 4)) pop = 0;
            else if ($urandom_range(0, 1) == 0) pop = 1;
            else pop = $urandom_range(0, 15);
            do_op($urandom_range(0, 299) == 0, p, $urandom, pop,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised successor to the core operand stack: configurable entry width, depth, maximum pop count per cycle and number of top-of-stack preview taps.
- Adds a combined pop-then-push operation in one cycle, explicit full/empty/count status, sticky overflow/underflow error flags and a high-water mark.
- Sits between the instruction decode/execute stage and the operand datapath. The execute stage issues push/pop each cycle and reads previews combinationally.

Parameters:
- DEPTH, 128, number of storage entries (>=2).
- WIDTH, 32, bits per entry.
- MAX_POP, 8, largest pop_cnt accepted in one cycle (1..DEPTH).
- NPREV, 2, number of preview taps (1..DEPTH).
- Derived: CW = $clog2(DEPTH+1), PW = $clog2(MAX_POP+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- push  in  1  push push_data this cycle, applied after any pop.
- push_data  in  WIDTH  data to push.
- pop_cnt  in  PW  entries to pop this cycle (0 = none); values >MAX_POP are treated as underflow.
- err_clr  in  1  clears sticky error flags.
- preview  out  NPREV*WIDTH  packed taps; slice i (LSB-first) = i-th entry below top.
- count  out  CW  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- hwm  out  CW  maximum count reached since reset or err_clr.
- err_overflow  out  1  sticky: a push was dropped.
- err_underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst_n low at posedge): count=0, hwm=0, both error flags 0. Memory is not cleared. All outputs are therefore 0 / empty=1 / full=0 the cycle after reset.
- Reset mid-operation wins over push/pop/err_clr in the same cycle.
- Per cycle (rst_n high), let c = count:
  - Underflow, when pop_cnt > c or pop_cnt > MAX_POP: the entire op (pop and any push) is discarded, count holds, err_underflow <= 1.
  - Otherwise, m = c - pop_cnt:
    - If push and m < DEPTH: mem[m] <= push_data and count <= m+1.
    - If push and m == DEPTH (full, no pop): the push is dropped, count <= m, err_overflow <= 1.
    - If no push: count <= m.
  - pop_cnt=0 and push=0: no change.
- Push at full combined with pop_cnt>=1 is legal: it replaces the top entries with no error.
- preview slice i = (count > i) ? mem[count-1-i] : 0. Purely combinational from registered state, so updates are visible the cycle after the op (1-cycle latency).
- hwm <= max(hwm, next count) each cycle.
- err_clr: clears both flags and sets hwm to the current count. If a new error occurs in the same cycle, that flag is set; set has priority over clear.
- Flags stay set until err_clr or reset. They never block subsequent valid operations.
- Width rules: all count arithmetic is CW+1 bits to avoid wrap. Memory is indexed with the CW-bit m.

Optional Feature:
- Macro STACK_PEEK_EN.
- Defined: adds ports peek_idx (in, CW) and peek_data (out, WIDTH).
  - peek_data = mem[count-1-peek_idx] if peek_idx < count, else 0.
  - Combinational, same timing as the preview taps.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package stack_pkg:
  - Default-parameter localparams.
  - A clog2-based width helper for CW/PW.
  - A typedef for the op record {push, pop_cnt}, reused by the decode stage.
- One sub-module, stack_mem: DEPTH x WIDTH register array with one write port and NPREV (+1 with STACK_PEEK_EN) asynchronous read ports, no reset.
- Pointer, flags and hwm logic live in stack_unit.

Test Plan:
- Reset then push 0xA, 0xB, 0xC on consecutive cycles -> count=3, preview0=0xC, preview1=0xB, hwm=3, empty=0, no errors.
- From count=3, pop_cnt=2 with push 0xD in one cycle -> count=2, preview0=0xD, preview1=0xA.
- Fill to DEPTH=128, then push 0xE with pop_cnt=0 -> count=128, full=1, err_overflow=1, preview0 unchanged. Next: push 0xF with pop_cnt=1 -> count=128, preview0=0xF, no new error.
- count=1, pop_cnt=3 with push=1 -> count stays 1, preview0 unchanged, err_underflow=1. Assert err_clr with a valid op -> flags 0, hwm=count.
- Same-cycle err_clr plus an underflow -> err_underflow remains 1.
- Mid-sequence rst_n=0 with push=1 -> next cycle count=0, preview all 0, hwm=0, flags 0.
- STACK_PEEK_EN build: after pushing 1..5, peek_idx=4 -> peek_data=1; peek_idx=5 -> 0.
